// File: rtl/mem_access_unit.sv
// Memory-stage access unit: runs single-outstanding loads/stores on a ready/ack bus,
// with little-endian lane alignment, load extension and an access timeout.
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        mem_sign,
  input  logic [1:0]  mem_size,
  input  logic [31:0] addr,
  input  logic [31:0] writedata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        stall,
  output logic [31:0] readdata,
  output logic        rdata_valid,
  output logic        bus_error,
  output logic        addr_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] be;
    case (size)
      2'b00:   be = 4'b0001 << lane;
      2'b01:   be = lane[1] ? 4'b1100 : 4'b0011;
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] w;
    case (size)
      2'b00:   w = {4{wdata[7:0]}};
      2'b01:   w = {2{wdata[15:0]}};
      default: w = wdata;
    endcase
    return w;
  endfunction

  // Halfword lanes are always 0 or 2 here because misaligned requests never reach the bus.
  function automatic logic [31:0] load_extract(input logic [1:0] size, input logic sign,
                                               input logic [1:0] lane, input logic [31:0] rdata);
    logic [31:0] sh;
    logic [31:0] r;
    sh = rdata >> {lane, 3'b000};
    case (size)
      2'b00:   r = {{24{sign & sh[7]}}, sh[7:0]};
      2'b01:   r = {{16{sign & sh[15]}}, sh[15:0]};
      default: r = rdata;
    endcase
    return r;
  endfunction

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [3:0]  bus_be_q, bus_be_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [1:0]  size_q, size_d;
  logic        sign_q, sign_d;
  logic [1:0]  lane_q, lane_d;
  logic [31:0] readdata_q, readdata_d;
  logic        rdata_valid_q, rdata_valid_d;
  logic        bus_error_q, bus_error_d;

  logic        req_s;
  logic        misaligned_s;
  logic        accept_s;

  // Request qualification and the combinational pipeline hold.
  always_comb begin
    req_s = mem_read | mem_write;
    case (mem_size)
      2'b00:   misaligned_s = 1'b0;
      2'b01:   misaligned_s = addr[0];
      2'b10:   misaligned_s = |addr[1:0];
      default: misaligned_s = 1'b1;
    endcase
    accept_s = (state_q == IDLE) & req_s & ~misaligned_s;
    addr_err = (state_q == IDLE) & req_s & misaligned_s;
    stall    = ~reset & (accept_s | (state_q == ACCESS));
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    bus_req_d     = bus_req_q;
    bus_we_d      = bus_we_q;
    bus_addr_d    = bus_addr_q;
    bus_be_d      = bus_be_q;
    bus_wdata_d   = bus_wdata_q;
    size_d        = size_q;
    sign_d        = sign_q;
    lane_d        = lane_q;
    readdata_d    = readdata_q;
    rdata_valid_d = 1'b0;
    bus_error_d   = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = 8'd0;
        if (accept_s) begin
          bus_req_d   = 1'b1;
          bus_we_d    = mem_write;
          bus_addr_d  = {addr[31:2], 2'b00};
          bus_be_d    = lane_be(mem_size, addr[1:0]);
          bus_wdata_d = lane_wdata(mem_size, writedata);
          size_d      = mem_size;
          sign_d      = mem_sign;
          lane_d      = addr[1:0];
          state_d     = ACCESS;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        cnt_d = cnt_q + 8'd1;
        // An ack on the final wait cycle still completes normally.
        if (bus_ack) begin
          bus_req_d = 1'b0;
          state_d   = DONE;
          if (!bus_we_q) begin
            readdata_d    = load_extract(size_q, sign_q, lane_q, bus_rdata);
            rdata_valid_d = 1'b1;
          end else begin
            readdata_d = readdata_q;
          end
        end else if (cnt_q == LAST_CNT) begin
          bus_req_d   = 1'b0;
          bus_error_d = 1'b1;
          state_d     = DONE;
        end else begin
          state_d = ACCESS;
        end
      end
      DONE: begin
        cnt_d   = 8'd0;
        state_d = IDLE;
      end
      default: begin
        cnt_d     = 8'd0;
        bus_req_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= 8'd0;
      bus_req_q     <= 1'b0;
      bus_we_q      <= 1'b0;
      bus_addr_q    <= 32'd0;
      bus_be_q      <= 4'd0;
      bus_wdata_q   <= 32'd0;
      size_q        <= 2'd0;
      sign_q        <= 1'b0;
      lane_q        <= 2'd0;
      readdata_q    <= 32'd0;
      rdata_valid_q <= 1'b0;
      bus_error_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bus_req_q     <= bus_req_d;
      bus_we_q      <= bus_we_d;
      bus_addr_q    <= bus_addr_d;
      bus_be_q      <= bus_be_d;
      bus_wdata_q   <= bus_wdata_d;
      size_q        <= size_d;
      sign_q        <= sign_d;
      lane_q        <= lane_d;
      readdata_q    <= readdata_d;
      rdata_valid_q <= rdata_valid_d;
      bus_error_q   <= bus_error_d;
    end
  end

  assign bus_req     = bus_req_q;
  assign bus_we      = bus_we_q;
  assign bus_addr    = bus_addr_q;
  assign bus_be      = bus_be_q;
  assign bus_wdata   = bus_wdata_q;
  assign readdata    = readdata_q;
  assign rdata_valid = rdata_valid_q;
  assign bus_error   = bus_error_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed cases plus randomized loads/stores
// against an arithmetic reference model of lanes, extension and latency.
module tb_mem_access_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read, mem_write, mem_sign;
  logic [1:0]  mem_size;
  logic [31:0] addr, writedata;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        stall;
  logic [31:0] readdata;
  logic        rdata_valid, bus_error, addr_err;

  mem_access_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .mem_sign(mem_sign), .mem_size(mem_size), .addr(addr), .writedata(writedata),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata), .stall(stall),
    .readdata(readdata), .rdata_valid(rdata_valid), .bus_error(bus_error),
    .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] baddr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    logic        rv;
    logic        err;
    logic [31:0] rd;
  } done_t;

  req_t  exp_req[$];
  done_t exp_done[$];
  int    tests  = 0;
  int    errors = 0;
  logic [31:0] model_rd;
  logic        prev_req = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] size);
    return 1 << size;
  endfunction

  function automatic logic [3:0] exp_be(input logic [1:0] size, input logic [31:0] a);
    int off = int'(a % 32'd4);
    return 4'(((1 << nbytes(size)) - 1) << off);
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [1:0] size, input logic [31:0] w);
    if (nbytes(size) == 1) return (w & 32'hFF) * 32'h0101_0101;
    else if (nbytes(size) == 2) return (w & 32'hFFFF) * 32'h0001_0001;
    else return w;
  endfunction

  function automatic logic [31:0] exp_load(input logic [1:0] size, input logic sign,
                                           input logic [31:0] a, input logic [31:0] rd);
    int bits = 8 * nbytes(size);
    int off  = 8 * int'(a % 32'd4);
    logic [63:0] mask;
    logic [63:0] v;
    mask = (64'd1 << bits) - 64'd1;
    v = ({32'd0, rd} >> off) & mask;
    if (sign && v[bits-1]) v = v | ~mask;
    return v[31:0];
  endfunction

  // Monitor: compare bus request fields when bus_req rises, and completions when flagged.
  always @(negedge clk) begin : monitor
    req_t  r;
    done_t d;
    if (reset) begin
      prev_req = 1'b0;
    end else begin
      if (bus_req && !prev_req) begin
        if (exp_req.size() == 0) begin
          check("unexpected_bus_req", 32'(bus_req), 32'd0);
        end else begin
          r = exp_req.pop_front();
          check("bus_we", 32'(bus_we), 32'(r.we));
          check("bus_addr", bus_addr, r.baddr);
          check("bus_be", 32'(bus_be), 32'(r.be));
          if (r.we) check("bus_wdata", bus_wdata, r.wdata);
        end
      end
      if (rdata_valid || bus_error) begin
        if (exp_done.size() == 0) begin
          check("unexpected_completion", {30'd0, rdata_valid, bus_error}, 32'd0);
        end else begin
          d = exp_done.pop_front();
          check("rdata_valid", 32'(rdata_valid), 32'(d.rv));
          check("bus_error", 32'(bus_error), 32'(d.err));
          check("readdata", readdata, d.rd);
        end
      end
      prev_req = bus_req;
    end
  end

  // One request; d = ack delay in ACCESS cycles (d >= TO means no ack, i.e. timeout).
  task automatic run_txn(input logic rd, input logic wr, input logic sign, input logic [1:0] size,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdat,
                         input int d);
    bit mis, acked;
    int done_c, stall_n, req_n;
    @(posedge clk); #1;
    mem_read = rd; mem_write = wr; mem_sign = sign; mem_size = size;
    addr = a; writedata = wd;
    bus_ack = 1'($urandom_range(0, 1));
    bus_rdata = $urandom;
    mis = (size == 2'b11) || ((a % 32'(nbytes(size))) != 32'd0);
    if (mis) begin
      @(negedge clk);
      check("addr_err", 32'(addr_err), 32'd1);
      check("stall_misaligned", 32'(stall), 32'd0);
      @(posedge clk); #1;
      bus_ack = 1'b0;
      @(negedge clk);
      check("bus_req_misaligned", 32'(bus_req), 32'd0);
      return;
    end
    acked  = d < TO;
    done_c = acked ? 2 + d : TO + 1;
    exp_req.push_back('{wr, a & ~32'h3, exp_be(size, a), exp_wdata(size, wd)});
    if (acked && !wr) begin
      model_rd = exp_load(size, sign, a, rdat);
      exp_done.push_back('{1'b1, 1'b0, model_rd});
    end else if (!acked) begin
      exp_done.push_back('{1'b0, 1'b1, model_rd});
    end
    @(negedge clk);
    check("addr_err_aligned", 32'(addr_err), 32'd0);
    stall_n = int'(stall);
    req_n   = int'(bus_req);
    for (int c = 1; c <= done_c; c++) begin
      @(posedge clk); #1;
      if (acked && c == 1 + d) begin
        bus_ack = 1'b1;
        bus_rdata = rdat;
      end else begin
        bus_ack = (c == done_c) ? 1'($urandom_range(0, 1)) : 1'b0;
        bus_rdata = $urandom;
      end
      @(negedge clk);
      stall_n += int'(stall);
      req_n   += int'(bus_req);
    end
    check("stall_cycles", 32'(stall_n), 32'(done_c));
    check("bus_req_cycles", 32'(req_n), 32'(done_c - 1));
    check("stall_done", 32'(stall), 32'd0);
    check("done_rdata_valid", 32'(rdata_valid), 32'(acked && !wr));
    check("done_bus_error", 32'(bus_error), 32'(!acked));
    check("done_readdata", readdata, model_rd);
    bus_ack = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      mem_read = 1'b0; mem_write = 1'b0;
      bus_ack = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("idle_quiet", {29'd0, bus_req, rdata_valid, bus_error}, 32'd0);
    end
    bus_ack = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int quiet;
    reset = 1'b1;
    mem_read = 1'b0; mem_write = 1'b0; mem_sign = 1'b0; mem_size = 2'b00;
    addr = 32'd0; writedata = 32'd0; bus_ack = 1'b0; bus_rdata = 32'd0;
    model_rd = 32'd0;
    #12;
    check("rst_bus_req", 32'(bus_req), 32'd0);
    check("rst_bus_we", 32'(bus_we), 32'd0);
    check("rst_bus_addr", bus_addr, 32'd0);
    check("rst_bus_be", 32'(bus_be), 32'd0);
    check("rst_bus_wdata", bus_wdata, 32'd0);
    check("rst_readdata", readdata, 32'd0);
    check("rst_flags", {30'd0, rdata_valid, bus_error}, 32'd0);
    mem_read = 1'b1; mem_size = 2'b10; addr = 32'h102;
    #1;
    check("rst_addr_err", 32'(addr_err), 32'd1);
    check("rst_stall", 32'(stall), 32'd0);
    mem_read = 1'b0; addr = 32'h100;
    #1;
    check("rst_stall_aligned", 32'(stall), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    run_txn(1'b1, 1'b0, 1'b0, 2'b10, 32'h100, 32'd0, 32'hDEAD_BEEF, 0);
    check("word_load", readdata, 32'hDEAD_BEEF);
    run_txn(1'b1, 1'b0, 1'b1, 2'b00, 32'h203, 32'd0, 32'h8012_3456, 1);
    check("byte_load_sext", readdata, 32'hFFFF_FF80);
    run_txn(1'b1, 1'b0, 1'b0, 2'b00, 32'h203, 32'd0, 32'h8012_3456, 2);
    check("byte_load_zext", readdata, 32'h0000_0080);
    run_txn(1'b0, 1'b1, 1'b0, 2'b01, 32'h12, 32'h0000_ABCD, 32'h1111_2222, 3);
    check("half_store_keeps_readdata", readdata, 32'h0000_0080);
    run_txn(1'b1, 1'b0, 1'b0, 2'b10, 32'h102, 32'd0, 32'd0, 0);
    run_txn(1'b1, 1'b0, 1'b1, 2'b10, 32'h8, 32'd0, 32'h1234_5678, 9);
    run_txn(1'b1, 1'b1, 1'b0, 2'b10, 32'h40, 32'hCAFE_F00D, 32'h0, 0);
    run_txn(1'b1, 1'b0, 1'b1, 2'b01, 32'h302, 32'd0, 32'h9ABC_1234, 0);
    idle_cycles(2);

    // Reset asserted between edges in the second ACCESS cycle.
    @(posedge clk); #1;
    mem_read = 1'b1; mem_write = 1'b0; mem_size = 2'b10; addr = 32'h440; bus_ack = 1'b0;
    exp_req.push_back('{1'b0, 32'h440, 4'b1111, 32'd0});
    @(posedge clk); #1;
    @(posedge clk); #2;
    check("bus_req_before_reset", 32'(bus_req), 32'd1);
    reset = 1'b1;
    #1;
    check("reset_bus_req_drop", 32'(bus_req), 32'd0);
    check("reset_stall_drop", 32'(stall), 32'd0);
    @(negedge clk);
    mem_read = 1'b0;
    reset = 1'b0;
    model_rd = 32'd0;
    quiet = 0;
    repeat (5) begin
      @(negedge clk);
      quiet += int'(rdata_valid | bus_req | stall | bus_error);
    end
    check("post_reset_quiet", 32'(quiet), 32'd0);
    check("post_reset_readdata", readdata, 32'd0);

    for (int i = 0; i < 80; i++) begin
      logic rd, wr;
      rd = 1'($urandom_range(0, 1));
      wr = rd ? 1'($urandom_range(0, 1)) : 1'b1;
      run_txn(rd, wr, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom,
              $urandom, $urandom, $urandom_range(0, 5));
      if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 2));
    end
    idle_cycles(2);
    check("req_queue_drained", 32'(exp_req.size()), 32'd0);
    check("done_queue_drained", 32'(exp_done.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
